// File: rtl/wb_cmd_initiator.sv
// Wishbone classic initiator: turns command-channel requests into single or
// incrementing-address read/write beats, one response per beat.
// Optional per-beat ack timeout is enabled by defining WB_CMD_INITIATOR_TIMEOUT_EN.
module wb_cmd_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    input  logic [7:0]  cmd_cnt,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        rsp_last,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    state_e      state_q;
    logic        cyc_q;
    logic        stb_q;
    logic        we_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [3:0]  sel_q;
    logic [7:0]  remaining_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_dat_q;
    logic        rsp_last_q;

    logic [31:0] adr_d;
    logic [7:0]  remaining_d;
    logic [7:0]  first_cnt_d;
    logic        ack_hit;
    logic        cmd_fire;
    logic        rsp_fire;

`ifdef WB_CMD_INITIATOR_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_cnt_q;
    logic       rsp_err_q;
    logic       tmo_hit;
    assign tmo_hit = (tmo_cnt_q == TMO_LAST);
`else
    logic unused_timeout_param;
    assign unused_timeout_param = (TIMEOUT_CYCLES == 0);
`endif

    // Combinational on reset so the port reads 0 while reset is held and 1
    // as soon as it is released.
    assign cmd_ready   = (state_q == ST_IDLE) && !wb_rst_i;
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign rsp_fire    = rsp_valid_q && rsp_ready;
    assign ack_hit     = stb_q && wbm_ack_i;
    assign adr_d       = adr_q + 32'd4;
    assign remaining_d = remaining_q - 8'd1;
    assign first_cnt_d = (cmd_cnt == 8'd0) ? 8'd1 : cmd_cnt;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= 32'd0;
            dat_q       <= 32'd0;
            sel_q       <= 4'd0;
            remaining_q <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 32'd0;
            rsp_last_q  <= 1'b0;
`ifdef WB_CMD_INITIATOR_TIMEOUT_EN
            tmo_cnt_q   <= 8'd0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        we_q        <= cmd_we;
                        adr_q       <= cmd_adr;
                        dat_q       <= cmd_dat;
                        sel_q       <= cmd_sel;
                        remaining_q <= first_cnt_d;
                        cyc_q       <= 1'b1;
                        stb_q       <= 1'b1;
`ifdef WB_CMD_INITIATOR_TIMEOUT_EN
                        tmo_cnt_q   <= 8'd0;
`endif
                        state_q     <= ST_BUS;
                    end
                end

                ST_BUS: begin
                    // An ack in the same cycle as timeout expiry takes priority.
                    if (ack_hit) begin
                        rsp_dat_q   <= we_q ? 32'd0 : wbm_dat_i;
                        rsp_last_q  <= (remaining_q == 8'd1);
                        rsp_valid_q <= 1'b1;
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
`ifdef WB_CMD_INITIATOR_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state_q     <= ST_RSP;
                    end
`ifdef WB_CMD_INITIATOR_TIMEOUT_EN
                    else if (tmo_hit) begin
                        rsp_dat_q   <= 32'd0;
                        rsp_err_q   <= 1'b1;
                        rsp_last_q  <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        state_q     <= ST_RSP;
                    end else begin
                        tmo_cnt_q   <= tmo_cnt_q + 8'd1;
                    end
`endif
                end

                ST_RSP: begin
                    if (rsp_fire) begin
                        rsp_valid_q <= 1'b0;
                        if (rsp_last_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            remaining_q <= remaining_d;
                            adr_q       <= adr_d;
                            cyc_q       <= 1'b1;
                            stb_q       <= 1'b1;
`ifdef WB_CMD_INITIATOR_TIMEOUT_EN
                            tmo_cnt_q   <= 8'd0;
`endif
                            state_q     <= ST_BUS;
                        end
                    end
                end

                default: begin
                    cyc_q       <= 1'b0;
                    stb_q       <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = sel_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_last  = rsp_last_q;
`ifdef WB_CMD_INITIATOR_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Self-checking bench for wb_cmd_initiator: directed cases plus randomized
// commands, checked against a per-beat address/data model built in the bench.
module tb_wb_cmd_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = 32'd0;
    logic [31:0] cmd_dat = 32'd0;
    logic [3:0]  cmd_sel = 4'd0;
    logic [7:0]  cmd_cnt = 8'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        rsp_last;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i = 32'd0;
    logic        wbm_ack_i = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_cmd_initiator #(.TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .cmd_cnt   (cmd_cnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .rsp_last  (rsp_last),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i)
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Issue one command and walk every beat; the target side is driven here.
    task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [7:0] cnt,
                           input int wait_max, input int bp_lo, input int bp_hi);
        int          beats;
        int          w;
        int          bp;
        logic [31:0] eadr;
        logic [31:0] rdata;
        logic [31:0] edat;
        beats = (cnt == 8'd0) ? 1 : int'(cnt);
        $display("cmd we=%0b adr=%h dat=%h sel=%h cnt=%0d beats=%0d", we, adr, dat, sel, cnt, beats);
        chk1("idle_cmd_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_cnt = cnt;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
        for (int i = 0; i < beats; i++) begin
            eadr = adr + 32'(4 * i);
            chk1("beat_stb", wbm_stb_o, 1'b1);
            chk1("beat_cyc", wbm_cyc_o, 1'b1);
            chk32("beat_adr", wbm_adr_o, eadr);
            chk1("beat_we", wbm_we_o, we);
            chk32("beat_dat_o", wbm_dat_o, dat);
            chk32("beat_sel", {28'd0, wbm_sel_o}, {28'd0, sel});
            chk1("busy_cmd_ready", cmd_ready, 1'b0);
            w = $urandom_range(0, wait_max);
            if (w > 0) begin
                repeat (w) @(negedge clk);
                chk1("wait_stb", wbm_stb_o, 1'b1);
            end
            rdata = $urandom;
            wbm_ack_i = 1'b1; wbm_dat_i = rdata;
            @(negedge clk);
            wbm_ack_i = 1'b0; wbm_dat_i = $urandom;
            edat = we ? 32'd0 : rdata;
            chk1("rsp_valid", rsp_valid, 1'b1);
            chk1("rsp_cyc_low", wbm_cyc_o, 1'b0);
            chk1("rsp_stb_low", wbm_stb_o, 1'b0);
            chk32("rsp_dat", rsp_dat, edat);
            chk1("rsp_err", rsp_err, 1'b0);
            chk1("rsp_last", rsp_last, (i == beats - 1));
            $display("  beat %0d adr=%h rsp_dat=%h last=%0b wait=%0d", i, eadr, rsp_dat, rsp_last, w);
            bp = $urandom_range(bp_lo, bp_hi);
            repeat (bp) begin
                wbm_ack_i = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk1("hold_valid", rsp_valid, 1'b1);
                chk32("hold_dat", rsp_dat, edat);
                chk1("hold_cyc", wbm_cyc_o, 1'b0);
                chk1("hold_cmd_ready", cmd_ready, 1'b0);
            end
            wbm_ack_i = 1'b0; rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        chk1("done_cmd_ready", cmd_ready, 1'b1);
        chk1("done_rsp_valid", rsp_valid, 1'b0);
        chk1("done_cyc", wbm_cyc_o, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi;
        logic [31:0] radr;

        // Reset state
        repeat (3) @(negedge clk);
        chk1("rst_cmd_ready", cmd_ready, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_rsp_err", rsp_err, 1'b0);
        chk1("rst_rsp_last", rsp_last, 1'b0);
        chk1("rst_cyc", wbm_cyc_o, 1'b0);
        chk1("rst_stb", wbm_stb_o, 1'b0);
        chk1("rst_we", wbm_we_o, 1'b0);
        chk32("rst_adr", wbm_adr_o, 32'd0);
        chk32("rst_dat_o", wbm_dat_o, 32'd0);
        chk32("rst_rsp_dat", rsp_dat, 32'd0);
        chk32("rst_sel", {28'd0, wbm_sel_o}, 32'd0);
        rst = 1'b0;
        #1;
        chk1("post_rst_cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);

        // Directed cases
        run_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF, 8'd1, 0, 0, 0);
        run_cmd(1'b1, 32'h3000_0000, 32'h1111_2222, 4'hF, 8'd4, 0, 0, 0);
        run_cmd(1'b0, 32'h3000_0100, 32'h0, 4'h3, 8'd2, 1, 5, 5);
        run_cmd(1'b1, 32'h3000_0040, 32'hDEAD_BEEF, 4'h5, 8'd0, 0, 0, 1);
        run_cmd(1'b0, 32'hFFFF_FFFC, 32'h0, 4'hC, 8'd2, 1, 0, 1);

        // Reset pulsed while a beat is on the bus
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0200; cmd_sel = 4'hF; cmd_cnt = 8'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk1("pre_rst_stb", wbm_stb_o, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("async_rst_cyc", wbm_cyc_o, 1'b0);
        chk1("async_rst_stb", wbm_stb_o, 1'b0);
        chk1("async_rst_valid", rsp_valid, 1'b0);
        chk1("async_rst_cmd_ready", cmd_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("rel_cmd_ready", cmd_ready, 1'b1);
        chk32("rel_adr", wbm_adr_o, 32'd0);
        wbm_ack_i = 1'b1;
        repeat (3) @(negedge clk);
        wbm_ack_i = 1'b0;
        chk1("rel_no_rsp", rsp_valid, 1'b0);
        chk1("rel_no_cyc", wbm_cyc_o, 1'b0);
        $display("reset during BUS done");

        // Target that never acks on a 3-beat read
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0300; cmd_sel = 4'hF; cmd_cnt = 8'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
`ifdef WB_CMD_INITIATOR_TIMEOUT_EN
        hi = 0;
        for (int k = 0; k < 50 && wbm_stb_o === 1'b1; k++) begin
            hi++;
            @(negedge clk);
        end
        chk32("timeout_stb_cycles", 32'(hi), 32'd8);
        chk1("timeout_rsp_valid", rsp_valid, 1'b1);
        chk1("timeout_rsp_err", rsp_err, 1'b1);
        chk1("timeout_rsp_last", rsp_last, 1'b1);
        chk32("timeout_rsp_dat", rsp_dat, 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk1("timeout_cmd_ready", cmd_ready, 1'b1);
        chk1("timeout_no_cyc", wbm_cyc_o, 1'b0);
        $display("timeout: stb high %0d cycles", hi);
`else
        hi = 0;
        for (int k = 0; k < 120; k++) begin
            if (wbm_cyc_o === 1'b1 && wbm_stb_o === 1'b1) hi++;
            @(negedge clk);
        end
        chk32("no_timeout_cyc_cycles", 32'(hi), 32'd120);
        chk1("no_timeout_rsp", rsp_valid, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("no_timeout_recover", cmd_ready, 1'b1);
        @(negedge clk);
        $display("no timeout: cyc high %0d cycles", hi);
`endif

        // Randomized commands
        for (int t = 0; t < 15; t++) begin
            radr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3)))
                                               : {$urandom} & 32'hFFFF_FFFC;
            run_cmd(1'($urandom_range(0, 1)), radr, $urandom, 4'($urandom), 8'($urandom_range(0, 5)),
                    2, 0, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_cmd_initiator.md
# wb_cmd_initiator

Wishbone classic initiator that turns simple command-channel requests into single or incrementing-burst read/write cycles towards the `toysram_site` Wishbone target. It sits on the user-project side, opposite the target's `wbs_*` port. It is driven by a local command source such as logic-analyzer or IO-pin glue, and returns one response per bus beat. It gives bench and silicon debug a path to the SRAM that does not depend on the management SoC.

## Interface
- `TIMEOUT_CYCLES`, default 255: number of stb-high cycles without ack before a beat is aborted (range 1..255).
- `wb_clk_i  in  1`: clock, rising edge.
- `wb_rst_i  in  1`: reset, asynchronous, active-high.
- `cmd_valid  in  1`: command present.
- `cmd_ready  out  1`: command accepted on `cmd_valid & cmd_ready`.
- `cmd_we  in  1`: 1 means write, 0 means read.
- `cmd_adr  in  32`: byte address of the first beat.
- `cmd_dat  in  32`: write data, reused for every beat of a burst.
- `cmd_sel  in  4`: byte selects.
- `cmd_cnt  in  8`: beat count; 0 is treated as 1.
- `rsp_valid  out  1`: response present.
- `rsp_ready  in  1`: response consumed on `rsp_valid & rsp_ready`.
- `rsp_dat  out  32`: read data; 0 for writes.
- `rsp_err  out  1`: beat timed out.
- `rsp_last  out  1`: final beat of the command.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o  out  1`: Wishbone control.
- `wbm_adr_o  out  32`, `wbm_dat_o  out  32`, `wbm_sel_o  out  4`: Wishbone address, data and selects.
- `wbm_dat_i  in  32`, `wbm_ack_i  in  1`: Wishbone return data and acknowledge.

## Operation
- FSM states: IDLE, BUS, RSP.
- **IDLE**
  - `cmd_ready`=1.
  - On accept, latch we/adr/dat/sel and set remaining = max(`cmd_cnt`,1).
  - Go to BUS.
- **BUS**
  - `wbm_cyc_o`=`wbm_stb_o`=1; adr/dat/sel/we come from the latched registers.
  - On `wbm_ack_i`: capture `wbm_dat_i` (reads) or 0 (writes) into `rsp_dat`, set `rsp_err`=0, drop cyc/stb, go to RSP.
- **RSP**
  - `rsp_valid`=1 and held stable until `rsp_ready`.
  - `rsp_last`=1 when remaining==1 or `rsp_err`=1.
  - On handshake, if `rsp_last`: go to IDLE.
  - Otherwise: decrement remaining, set adr += 4, go to BUS.
- Address arithmetic is 32-bit modulo: 0xFFFF_FFFC + 4 wraps to 0x0000_0000.
- `wbm_ack_i` is ignored whenever stb is low.
- No pipelined or burst Wishbone tags; every beat is an independent classic cycle, with cyc low for at least one cycle between beats.
- Commands arriving while not in IDLE are stalled (`cmd_ready`=0), not dropped.

## Timing
- **Reset values:**
  - `cmd_ready`=0 while `wb_rst_i`=1, and 1 in the first cycle after release.
  - `rsp_valid`, `rsp_err`, `rsp_last`, `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` = 0.
  - `wbm_adr_o`, `wbm_dat_o`, `rsp_dat` = 0; `wbm_sel_o`=0.
- **Latency:**
  - Accept at edge N puts stb high in cycle N+1.
  - An ack sampled at edge N+1 (zero-wait target) puts `rsp_valid` high in cycle N+2, with cyc/stb already low.
- **Per-beat period:** minimum 2 cycles when `rsp_ready` is held high.
- **Reset mid-operation:** cyc/stb and `rsp_valid` drop asynchronously, and the in-flight command is discarded with no response.
- **Simultaneous ack and timeout expiry** in the same cycle: the ack wins and `rsp_err`=0.

## Configuration
- Macro `WB_CMD_INITIATOR_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit counter, cleared on entry to BUS, counts stb-high cycles.
  - When the count reaches `TIMEOUT_CYCLES` with no ack, cyc/stb drop, and RSP presents `rsp_err`=1, `rsp_dat`=0, `rsp_last`=1.
  - The remaining beats of the command are abandoned.
- **Undefined:** no counter; BUS waits for ack indefinitely; `rsp_err` is tied to 0; `TIMEOUT_CYCLES` is unused.

## Test plan
- **Single read:** `cmd_we`=0, adr 0x3000_0010, cnt 1, zero-wait target returning 0xA5A5_1234 → stb high 1 cycle, `rsp_dat`=0xA5A5_1234, `rsp_last`=1, `rsp_err`=0, response 2 cycles after accept.
- **Write burst:** cnt 4, adr 0x3000_0000, dat 0x1111_2222, sel 0xF → four cycles at 0x..00/04/08/0C with `wbm_we_o`=1, four responses with `rsp_dat`=0, `rsp_last` only on the 4th.
- **Backpressure:** `rsp_ready` low for 5 cycles during a 2-beat read → `rsp_valid`/`rsp_dat` held stable, no second bus cycle starts until the handshake, `cmd_ready`=0 throughout.
- **Timeout** (macro defined, `TIMEOUT_CYCLES`=8): target never acks on a 3-beat read → cyc drops after 8 stb cycles, one response with `rsp_err`=1, `rsp_last`=1, then `cmd_ready`=1. With the macro undefined, the same stimulus keeps cyc high for 100+ cycles.
- **Edge cases:**
  - cnt=0 → exactly one beat.
  - Adr 0xFFFF_FFFC with cnt 2 → second beat at 0x0000_0000.
  - `wb_rst_i` pulsed during BUS → cyc low immediately, no `rsp_valid`, `cmd_ready`=1 in the first cycle after release.
